// File: rtl/fp_divider_seq.sv
// fp_divider_seq: iterative IEEE-754 single-precision divider, out = a / b.
// The quotient significand is produced RADIX_BITS bits per cycle by restoring division.
// Optional build macro FPD_FLAGS_EN adds flags[4:0] = {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_divider_seq #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FPD_FLAGS_EN
    output logic [4:0]  flags,
`endif
    output logic [31:0] out
);
    localparam int          QBITS      = 26;  // 24 significand + guard + round
    localparam int          DIV_CYCLES = (QBITS + RADIX_BITS - 1) / RADIX_BITS;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, SPECIAL, DIV, NORM, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       out_q, out_d;
    logic [25:0]       rem_q, rem_d;   // partial remainder, always < 2*divisor after a step
    logic [23:0]       dvs_q, dvs_d;   // divisor significand {1, mb}
    logic [25:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic signed [9:0] exp_q, exp_d;

    logic sign;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = rst_n && (state_q == DONE);
    assign out       = out_q;

    // Classify the latched operands; subnormals count as zero (flush-to-zero).
    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    end

    logic        special;
    logic [31:0] special_res;

    // Resolve special operand combinations in priority order.
    always_comb begin
        special     = 1'b1;
        special_res = {sign, 31'd0};
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            special_res = QNAN;
        end else if (a_inf || b_zero) begin
            special_res = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            special_res = {sign, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    logic [25:0] step_rem, step_quo;

    // Retire RADIX_BITS restoring-division steps per DIV cycle.
    always_comb begin
        // NOTE: blocking assignments chain the unrolled steps within one cycle;
        // registers themselves are only ever updated with <= in always_ff.
        step_rem = rem_q;
        step_quo = quo_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (step_rem >= {2'b00, dvs_q}) begin
                step_rem = (step_rem - {2'b00, dvs_q}) << 1;
                step_quo = {step_quo[24:0], 1'b1};
            end else begin
                step_rem = step_rem << 1;
                step_quo = {step_quo[24:0], 1'b0};
            end
        end
    end

    logic [25:0]       nq;
    logic signed [9:0] ne;
    logic              guard, rnd, sticky, round_up, ovf, unf;
    logic [24:0]       sum;
    logic [22:0]       mant;
    logic [31:0]       norm_res;

    // Normalise the quotient, round to nearest even and apply range limits.
    always_comb begin
        nq = quo_q;
        ne = exp_q;
        if (!quo_q[25]) begin
            nq = {quo_q[24:0], 1'b0};
            ne = exp_q - 10'sd1;
        end
        guard    = nq[1];
        rnd      = nq[0];
        sticky   = |rem_q;
        round_up = guard && (rnd || sticky || nq[2]);
        sum      = {1'b0, nq[25:2]} + {24'd0, round_up};
        mant     = sum[22:0];
        if (sum[24]) begin
            mant = sum[23:1];
            ne   = ne + 10'sd1;
        end
        ovf = (ne >= 10'sd255);
        unf = (ne <= 10'sd0);
        if (ovf) begin
            norm_res = {sign, 8'hFF, 23'd0};
        end else if (unf) begin
            norm_res = {sign, 31'd0};
        end else begin
            norm_res = {sign, ne[7:0], mant};
        end
    end

    // Next-state and datapath register updates for the operation sequence.
    always_comb begin
        // NOTE: every target gets a hold value first, so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = SPECIAL;
                end
            end
            SPECIAL: begin
                rem_d = {3'b001, a_q[22:0]};
                dvs_d = {1'b1, b_q[22:0]};
                quo_d = '0;
                cnt_d = 5'(DIV_CYCLES);
                exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                if (special) begin
                    out_d   = special_res;
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = NORM;
            end
            NORM: begin
                out_d   = norm_res;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Working registers; every field is rewritten before it is read, so they carry no reset.
    always_ff @(posedge clk) begin
        // NOTE: leaving pure datapath registers out of reset keeps the reset net small;
        // only the FSM and visible outputs need a defined value.
        a_q   <= a_d;
        b_q   <= b_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        quo_q <= quo_d;
        cnt_q <= cnt_d;
        exp_q <= exp_d;
    end

`ifdef FPD_FLAGS_EN
    logic [4:0] flags_q, flags_d;

    // Capture exception flags together with the result they describe.
    always_comb begin
        flags_d = flags_q;
        if (state_q == SPECIAL) begin
            flags_d    = 5'd0;
            flags_d[4] = special && (special_res == QNAN);
            flags_d[3] = special && b_zero && !a_zero && !a_inf && !a_nan;
        end else if (state_q == NORM) begin
            flags_d = {2'b00, ovf, unf, guard || rnd || sticky || ovf || unf};
        end
    end

    // Flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) flags_q <= 5'd0;
        else        flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_divider_seq.sv
// Self-checking bench for fp_divider_seq: directed vectors plus randomised
// operands compared against an integer-arithmetic model of FP32 division.
`timescale 1ns/1ps
module tb_fp_divider_seq;
    localparam int RADIX_BITS  = 1;
    localparam int LAT_NORMAL  = (26 + RADIX_BITS - 1) / RADIX_BITS + 3;
    localparam int LAT_SPECIAL = 2;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
        logic        spec;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
`ifdef FPD_FLAGS_EN
    logic [4:0]  flags;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_divider_seq #(.RADIX_BITS(RADIX_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FPD_FLAGS_EN
        .flags     (flags),
`endif
        .out       (out)
    );

    // Reference: exact integer quotient, then round-to-nearest-even by comparing
    // the discarded part against one half.
    function automatic ref_t ref_div(input logic [31:0] x, input logic [31:0] y);
        ref_t r;
        int ex, ey, e;
        longint unsigned num, den, q, rm, sig, rest, half;
        logic s, xz, yz, xi, yi, xn, yn, up;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        r.flg  = 5'd0;
        r.spec = 1'b1;
        if (xn || yn || (xi && yi) || (xz && yz)) begin
            r.res = 32'h7FC00000;
            r.flg = 5'b10000;
            return r;
        end
        if (xi) begin
            r.res = {s, 8'hFF, 23'd0};
            return r;
        end
        if (yz) begin
            r.res = {s, 8'hFF, 23'd0};
            r.flg = 5'b01000;
            return r;
        end
        if (xz || yi) begin
            r.res = {s, 31'd0};
            return r;
        end
        r.spec = 1'b0;
        num = (64'h80_0000 | 64'(x[22:0])) << 40;
        den = 64'h80_0000 | 64'(y[22:0]);
        q   = num / den;
        rm  = num % den;
        e   = ex - ey + 127;
        if (q >= (64'd1 << 40)) begin
            sig  = q >> 17;
            rest = q & 64'h1FFFF;
            half = 64'h10000;
        end else begin
            sig  = q >> 16;
            rest = q & 64'hFFFF;
            half = 64'h8000;
            e    = e - 1;
        end
        up = (rest > half) || ((rest == half) && ((rm != 0) || ((sig & 64'd1) != 0)));
        if (up) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.flg = 5'b00101;
        end else if (e <= 0) begin
            r.res = {s, 31'd0};
            r.flg = 5'b00011;
        end else begin
            r.res = {s, 8'(e), 23'(sig)};
            r.flg = {4'b0000, (rest != 0) || (rm != 0)};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
            2:       v[30:23] = 8'($urandom_range(1, 12));
            3:       v[30:23] = 8'($urandom_range(243, 254));
            4:       v[22:0]  = 23'h7FFFFF;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Issue one operation and wait (bounded) for the result; optionally hand it off.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic release_out,
                          output logic [31:0] res, output logic [4:0] fl, output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        op_a = xa;
        op_b = xb;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 200);
        res = out;
`ifdef FPD_FLAGS_EN
        fl = flags;
`else
        fl = 5'd0;
`endif
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout a=%h b=%h: out_valid never rose within %0d cycles", xa, xb, lat);
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_hs: in_ready,out_valid=%b expected 00", {in_ready, out_valid});
        end
        n_cmp++;
        if (out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_out: got %h expected 00000000", out);
        end
`ifdef FPD_FLAGS_EN
        n_cmp++;
        if (flags !== 5'd0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000", flags);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_exact();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        run_op(32'h41C30000, 32'h40700000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 32'h40D00000) begin
            n_err++;
            $display("FAIL exact_out: got %h expected 40d00000", r);
        end
        n_cmp++;
        if (lat !== LAT_NORMAL) begin
            n_err++;
            $display("FAIL exact_latency: got %0d expected %0d", lat, LAT_NORMAL);
        end
`ifdef FPD_FLAGS_EN
        n_cmp++;
        if (f !== 5'd0) begin
            n_err++;
            $display("FAIL exact_flags: got %b expected 00000", f);
        end
`endif
    endtask

    task automatic test_rounding();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        run_op(32'h3F800000, 32'h40400000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 32'h3EAAAAAB) begin
            n_err++;
            $display("FAIL round_pos: got %h expected 3eaaaaab", r);
        end
`ifdef FPD_FLAGS_EN
        n_cmp++;
        if (f !== 5'b00001) begin
            n_err++;
            $display("FAIL round_flags: got %b expected 00001", f);
        end
`endif
        run_op(32'hBF800000, 32'h40400000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 32'hBEAAAAAB) begin
            n_err++;
            $display("FAIL round_neg: got %h expected beaaaaab", r);
        end
    endtask

    task automatic test_special();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vr [4];
        logic [4:0]  vf [4];
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        va = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h80000000};
        vb = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000};
        vr = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
        vf = '{5'b01000,     5'b10000,     5'b10000,     5'b00000};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b1, r, f, lat);
            n_cmp++;
            if (r !== vr[i] || lat !== LAT_SPECIAL) begin
                n_err++;
                $display("FAIL special_%0d: got %h lat %0d expected %h lat %0d", i, r, lat, vr[i], LAT_SPECIAL);
            end
`ifdef FPD_FLAGS_EN
            n_cmp++;
            if (f !== vf[i]) begin
                n_err++;
                $display("FAIL special_flags_%0d: got %b expected %b", i, f, vf[i]);
            end
`endif
        end
    endtask

    task automatic test_range();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        run_op(32'h7F7FFFFF, 32'h3F000000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 32'h7F800000) begin
            n_err++;
            $display("FAIL overflow: got %h expected 7f800000", r);
        end
`ifdef FPD_FLAGS_EN
        n_cmp++;
        if (f !== 5'b00101) begin
            n_err++;
            $display("FAIL overflow_flags: got %b expected 00101", f);
        end
`endif
        run_op(32'h00800000, 32'h40000000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 32'h00000000) begin
            n_err++;
            $display("FAIL underflow: got %h expected 00000000", r);
        end
`ifdef FPD_FLAGS_EN
        n_cmp++;
        if (f !== 5'b00011) begin
            n_err++;
            $display("FAIL underflow_flags: got %b expected 00011", f);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] xa, xb, r;
        logic [4:0]  f;
        int          lat, exp_lat;
        ref_t        m;
        for (int i = 0; i < 80; i++) begin
            xa = rand_fp();
            xb = rand_fp();
            m  = ref_div(xa, xb);
            exp_lat = m.spec ? LAT_SPECIAL : LAT_NORMAL;
            run_op(xa, xb, ($urandom_range(0, 1) == 1), r, f, lat);
            if (out_valid) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
            n_cmp++;
            if (r !== m.res || lat !== exp_lat) begin
                n_err++;
                $display("FAIL random_%0d %h/%h: got %h lat %0d expected %h lat %0d", i, xa, xb, r, lat, m.res, exp_lat);
            end
`ifdef FPD_FLAGS_EN
            n_cmp++;
            if (f !== m.flg) begin
                n_err++;
                $display("FAIL random_flags_%0d %h/%h: got %b expected %b", i, xa, xb, f, m.flg);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, held;
        logic [4:0]  f;
        int          lat, bad;
        ref_t        m;
        m = ref_div(32'h40490FDB, 32'h402DF854);
        run_op(32'h40490FDB, 32'h402DF854, 1'b0, held, f, lat);
        n_cmp++;
        if (held !== m.res) begin
            n_err++;
            $display("FAIL bp_result: got %h expected %h", held, m.res);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a = $urandom;
            op_b = $urandom;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== held) bad++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d of 10 stalled cycles lost out_valid/out or raised in_ready, expected 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_handoff: out_valid,in_ready=%b expected 01", {out_valid, in_ready});
        end
        m = ref_div(32'h42F60000, 32'hC1200000);
        run_op(32'h42F60000, 32'hC1200000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== m.res) begin
            n_err++;
            $display("FAIL bp_next_op: got %h expected %h", r, m.res);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat, seen;
        op_a = 32'h41C30000;
        op_b = 32'h40700000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_div_async_view: out_valid,in_ready=%b expected 00", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00 || out !== 32'h0) begin
            n_err++;
            $display("FAIL rst_div_during: out_valid,in_ready=%b out=%h expected 00 00000000", {out_valid, in_ready}, out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_div_release: in_ready=%b expected 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < LAT_NORMAL + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rst_div_no_result: out_valid high %0d cycles expected 0", seen);
        end
        run_op(32'h40C00000, 32'h40000000, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 32'h40400000 || lat !== LAT_NORMAL) begin
            n_err++;
            $display("FAIL rst_div_new_op: got %h lat %0d expected 40400000 lat %0d", r, lat, LAT_NORMAL);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_rounding();
        test_special();
        test_range();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_divider_seq.md
Name: fp_divider_seq

Overview:
Iterative FP32 (IEEE-754 single) divider computing out = a / b. It is the inverse-operation companion to the combinational FP32 multiplier and serves the matrix-multiplier datapath for normalisation and scaling. Operands enter through a valid/ready handshake, the quotient mantissa is produced RADIX_BITS bits per cycle, and the result leaves through a valid/ready handshake.

Parameters:
RADIX_BITS, 1, quotient bits retired per DIV cycle; legal values are 1 or 2.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  a/b valid
in_ready  output  1  divider can accept operands
a  input  32  dividend, FP32
b  input  32  divisor, FP32
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  32  quotient, FP32

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled on the clk rising edge). While reset is asserted: state=IDLE, in_ready=0, out_valid=0, out=32'h0. in_ready=1 from the first cycle after reset release.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a/b, unpack, go to SPECIAL.
  - SPECIAL: classify operands. A special case writes its result and goes to DONE. Otherwise go to DIV.
  - DIV: restoring division of {1,ma} by {1,mb}. Produces 26 quotient bits (24 significand + guard + round) in ceil(26/RADIX_BITS) cycles, then goes to NORM.
  - NORM: normalise, round, pack; go to DONE.
  - DONE: out_valid=1 and out held stable until out_ready=1, then go to IDLE.
- in_ready=1 only in IDLE. There is no overlap of operations.
- Latency from accept to out_valid: 2 cycles for special cases, ceil(26/RADIX_BITS)+3 cycles for normal operands.
- Subnormal inputs are flushed to signed zero before classification. There are no subnormal outputs.
- Sign = a[31]^b[31] for all results, including zero and inf. NaN results are always 32'h7FC00000.
- Special cases, in priority order:
  1. Either operand NaN -> qNaN.
  2. inf/inf or 0/0 -> qNaN.
  3. inf/x -> inf.
  4. x/0 -> inf.
  5. 0/x or x/inf -> zero.
- Exponent: e = ea - eb + 127, held in a 10-bit signed register.
  - If quotient bit 25 = 0: shift the quotient left by 1 and e = e - 1.
- Rounding: round-to-nearest-even.
  - Guard = bit 1, round = bit 0, sticky = (remainder != 0).
  - If rounding carries out of the significand: shift right and e = e + 1.
- Range limits, applied after rounding:
  - e >= 255 -> inf (overflow).
  - e <= 0 -> signed zero (underflow, flush).
- Asserting rst_n=0 mid-operation aborts the operation immediately; no partial result is emitted.
- If out_ready=1 already in the first DONE cycle, the result is handed off in that cycle; IDLE (in_ready=1) follows on the next cycle.

Optional Feature:
FPD_FLAGS_EN
- Defined: adds output port flags[4:0] = {invalid, div_by_zero, overflow, underflow, inexact}.
  - Flags are valid with out_valid and held while out_valid=1.
  - Reset value is 0.
  - div_by_zero is set for finite-nonzero/0.
  - inexact is set when guard|round|sticky is nonzero, and on overflow or underflow.
- Undefined: the flags port and all flag logic are absent; out is identical in both builds.

Test Plan:
- Exact division: a=0x41C30000 (24.375), b=0x40700000 (3.75) -> out=0x40D00000 (6.5). out_valid exactly ceil(26/RADIX_BITS)+3 cycles after accept; with FPD_FLAGS_EN, flags=0.
- Rounding: 0x3F800000/0x40400000 (1/3) -> 0x3EAAAAAB with round-up; with FPD_FLAGS_EN, inexact=1. Also 0xBF800000/0x40400000 -> 0xBEAAAAAB.
- Special cases, each out_valid 2 cycles after accept:
  - 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0x00000000/0x00000000 -> 0x7FC00000, invalid=1.
  - 0x7F800000/0x7F800000 -> 0x7FC00000.
  - 0x80000000/0x40000000 -> 0x80000000.
- Overflow/underflow:
  - 0x7F7FFFFF/0x3F000000 -> 0x7F800000, overflow=1.
  - 0x00800000/0x40000000 -> 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 -> handoff, then in_ready=1 on the next cycle.
- Reset mid-DIV: assert rst_n=0 for 1 cycle during DIV -> out_valid=0 and in_ready=0 during reset, in_ready=1 after reset release. A new operation, 0x40C00000/0x40000000, then yields 0x40400000.
